// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin fetch/data arbiter for a shared 32-bit memory with wait states and legality checks
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int MEM_BYTES   = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_adr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] m_adr,
    output logic [31:0] m_din,
    output logic        m_mrd,
    output logic        m_mwr,
    input  logic [31:0] m_dout
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t      state;
    logic        prio_d;
    logic        sel_d;
    logic        we;
    logic [3:0]  cnt;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        grant_d;
    logic        legal;
    logic [31:0] g_adr;

    // data wins when it is the only requester or when it holds the priority token
    assign grant_d = d_req && (!i_req || prio_d);
    assign g_adr   = grant_d ? d_adr : i_adr;
    assign legal   = (g_adr[1:0] == 2'b00) && (g_adr <= 32'(MEM_BYTES - 4));

    // memory side is quiet outside ACCESS; a store writes only on the edge leaving ACCESS
    assign m_adr = (state == ACCESS) ? adr : '0;
    assign m_din = (state == ACCESS) ? wdata : '0;
    assign m_mrd = (state == ACCESS) && !we;
    assign m_mwr = (state == ACCESS) && we && (cnt == 4'd0);

    // arbitration, wait-state sequencing and registered ack/err/rdata
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            prio_d  <= 1'b1;
            sel_d   <= 1'b0;
            we      <= 1'b0;
            cnt     <= '0;
            adr     <= '0;
            wdata   <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_ack   <= 1'b0;
            i_err   <= 1'b0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            i_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            case (state)
                IDLE: if (i_req || d_req) begin
                    sel_d  <= grant_d;
                    adr    <= g_adr;
                    we     <= grant_d && d_we;
                    wdata  <= grant_d ? d_wdata : '0;
                    prio_d <= !grant_d;
                    cnt    <= 4'(WAIT_CYCLES);
                    if (legal) begin
                        state <= ACCESS;
                    end else begin
                        state <= DONE;
                        i_ack <= !grant_d;
                        i_err <= !grant_d;
                        d_ack <= grant_d;
                        d_err <= grant_d;
                    end
                end
                ACCESS: if (cnt == 4'd0) begin
                    state <= DONE;
                    i_ack <= !sel_d;
                    d_ack <= sel_d;
                    if (!we && sel_d) d_rdata <= m_dout;
                    if (!we && !sel_d) i_rdata <= m_dout;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
